// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, derived widths and common types
// for the VGA sync generator and its generation-tick controller.
package vga_pkg;

   localparam int H_VISIBLE = 640;
   localparam int H_FP      = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BP      = 48;
   localparam int H_TOTAL   = 800;

   localparam int V_VISIBLE = 480;
   localparam int V_FP      = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BP      = 33;
   localparam int V_TOTAL   = 525;

   localparam int H_W   = $clog2(H_TOTAL);
   localparam int V_W   = $clog2(V_TOTAL);
   localparam int X_W   = $clog2(H_VISIBLE);
   localparam int Y_W   = $clog2(V_VISIBLE);
   localparam int CNT_W = 8;

   // Sized boundary values so every decode compare is width-matched.
   localparam logic [H_W-1:0] H_VIS_LAST   = H_W'(H_VISIBLE - 1);
   localparam logic [H_W-1:0] H_SYNC_FIRST = H_W'(H_VISIBLE + H_FP);
   localparam logic [H_W-1:0] H_SYNC_LAST  = H_W'(H_VISIBLE + H_FP + H_SYNC - 1);
   localparam logic [H_W-1:0] H_LAST       = H_W'(H_TOTAL - 1);

   localparam logic [V_W-1:0] V_VIS_LAST   = V_W'(V_VISIBLE - 1);
   localparam logic [V_W-1:0] V_SYNC_FIRST = V_W'(V_VISIBLE + V_FP);
   localparam logic [V_W-1:0] V_SYNC_LAST  = V_W'(V_VISIBLE + V_FP + V_SYNC - 1);
   localparam logic [V_W-1:0] V_LAST       = V_W'(V_TOTAL - 1);
   localparam logic [V_W-1:0] V_VBLANK     = V_W'(V_VISIBLE);

   typedef enum logic {
      STEP_IDLE  = 1'b0,
      STEP_ARMED = 1'b1
   } step_state_t;

   typedef struct packed {
      logic           h_sync;
      logic           v_sync;
      logic           video_on;
      logic [X_W-1:0] pixel_x;
      logic [Y_W-1:0] pixel_y;
      logic           frame_start;
      logic           vblank_start;
   } sync_out_t;

endpackage

// File: rtl/gen_tick_ctrl.sv
// Frame counter and single-step latch that decide when the Game-of-Life
// engine advances; genTick is registered to line up with vblankStart.
module gen_tick_ctrl
   import vga_pkg::*;
#(
   parameter int FRAMES_PER_GEN = 30
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic step,
   input  logic vblank_evt,
   output logic gen_tick
);

   localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(FRAMES_PER_GEN - 1);

   logic [CNT_W-1:0] frame_cnt;
   logic [CNT_W-1:0] frame_cnt_next;
   step_state_t      step_state;
   step_state_t      step_state_next;
   logic             tick_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt  <= '0;
         step_state <= STEP_IDLE;
         gen_tick   <= 1'b0;
      end else begin
         frame_cnt  <= frame_cnt_next;
         step_state <= step_state_next;
         gen_tick   <= tick_next;
      end
   end

   // Running drops any armed step; while paused a step tick leaves the count alone.
   always_comb begin
      frame_cnt_next  = frame_cnt;
      step_state_next = step_state;
      tick_next       = 1'b0;
      if (run) begin
         step_state_next = STEP_IDLE;
         if (vblank_evt) begin
            if (frame_cnt == LAST_FRAME) begin
               frame_cnt_next = '0;
               tick_next      = 1'b1;
            end else begin
               frame_cnt_next = frame_cnt + 1'b1;
            end
         end
      end else if (vblank_evt && (step_state == STEP_ARMED)) begin
         tick_next       = 1'b1;
         step_state_next = STEP_IDLE;
      end else if (step) begin
         step_state_next = STEP_ARMED;
      end
   end

endmodule

// File: rtl/vga_sync_gen.sv
// Decodes externally supplied H/V counts into registered VGA sync, video
// and pulse outputs, and hosts the generation-tick controller.
module vga_sync_gen
   import vga_pkg::*;
#(
   parameter int FRAMES_PER_GEN = 30
) (
   input  logic           pixelClk,
   input  logic           rst,
   input  logic [H_W-1:0] hCount,
   input  logic [V_W-1:0] vCount,
   input  logic           run,
   input  logic           step,
   output logic           hSync,
   output logic           vSync,
   output logic           videoOn,
   output logic [X_W-1:0] pixelX,
   output logic [Y_W-1:0] pixelY,
   output logic           frameStart,
   output logic           vblankStart,
   output logic           genTick
);

   sync_out_t dec;
   sync_out_t out_q;
   logic      in_range;

   // Out-of-range counts must never pull a sync low, hence the in_range gate.
   always_comb begin
      dec              = '0;
      in_range         = (hCount <= H_LAST) && (vCount <= V_LAST);
      dec.video_on     = (hCount <= H_VIS_LAST) && (vCount <= V_VIS_LAST);
      dec.h_sync       = !(in_range && (hCount >= H_SYNC_FIRST) && (hCount <= H_SYNC_LAST));
      dec.v_sync       = !(in_range && (vCount >= V_SYNC_FIRST) && (vCount <= V_SYNC_LAST));
      dec.frame_start  = (hCount == '0) && (vCount == '0);
      dec.vblank_start = (hCount == '0) && (vCount == V_VBLANK);
      if (dec.video_on) begin
         dec.pixel_x = hCount[X_W-1:0];
         dec.pixel_y = vCount[Y_W-1:0];
      end
   end

   always_ff @(posedge pixelClk) begin
      if (rst) begin
         out_q        <= '0;
         out_q.h_sync <= 1'b1;
         out_q.v_sync <= 1'b1;
      end else begin
         out_q <= dec;
      end
   end

   gen_tick_ctrl #(
      .FRAMES_PER_GEN(FRAMES_PER_GEN)
   ) u_ctrl (
      .clk       (pixelClk),
      .rst       (rst),
      .run       (run),
      .step      (step),
      .vblank_evt(dec.vblank_start),
      .gen_tick  (genTick)
   );

   assign hSync       = out_q.h_sync;
   assign vSync       = out_q.v_sync;
   assign videoOn     = out_q.video_on;
   assign pixelX      = out_q.pixel_x;
   assign pixelY      = out_q.pixel_y;
   assign frameStart  = out_q.frame_start;
   assign vblankStart = out_q.vblank_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: a frame-per-gen=3 instance for most checks
// plus a frame-per-gen=1 instance sharing the same stimulus.
module tb_vga_sync_gen;

   logic       pixelClk = 1'b0;
   logic       rst;
   logic       run;
   logic       step;
   logic [9:0] hCount;
   logic [9:0] vCount;

   logic       hSync, vSync, videoOn, frameStart, vblankStart, genTick;
   logic [9:0] pixelX;
   logic [8:0] pixelY;

   logic       h_sync1, v_sync1, video_on1, frame_start1, vblank_start1, gen_tick1;
   logic [9:0] pixel_x1;
   logic [8:0] pixel_y1;

   int total = 0;
   int bad   = 0;

   vga_sync_gen #(.FRAMES_PER_GEN(3)) dut (
      .pixelClk(pixelClk), .rst(rst), .hCount(hCount), .vCount(vCount),
      .run(run), .step(step), .hSync(hSync), .vSync(vSync), .videoOn(videoOn),
      .pixelX(pixelX), .pixelY(pixelY), .frameStart(frameStart),
      .vblankStart(vblankStart), .genTick(genTick)
   );

   vga_sync_gen #(.FRAMES_PER_GEN(1)) dut1 (
      .pixelClk(pixelClk), .rst(rst), .hCount(hCount), .vCount(vCount),
      .run(run), .step(step), .hSync(h_sync1), .vSync(v_sync1), .videoOn(video_on1),
      .pixelX(pixel_x1), .pixelY(pixel_y1), .frameStart(frame_start1),
      .vblankStart(vblank_start1), .genTick(gen_tick1)
   );

   always #20 pixelClk = ~pixelClk;

   typedef struct {
      logic [9:0] h;
      logic [9:0] v;
      logic       vid;
      logic       hs;
      logic       vs;
      logic [9:0] x;
      logic [8:0] y;
      logic       fs;
      logic       vb;
   } vec_t;

   vec_t vecs[19];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [9:0] h, input logic [9:0] v);
      hCount = h;
      vCount = v;
      @(posedge pixelClk);
      #1;
   endtask

   function automatic logic model_video(int h, int v);
      return (h < 640) && (v < 480);
   endfunction

   function automatic logic model_hs(int h, int v);
      return !((h < 800) && (v < 525) && (h >= 656) && (h <= 751));
   endfunction

   function automatic logic model_vs(int h, int v);
      return !((h < 800) && (v < 525) && (v >= 490) && (v <= 491));
   endfunction

   // One compressed frame: only the counts the DUT decodes specially matter.
   task automatic runFrame(input string tag, input logic exp_tick, input logic exp_tick1,
                           input int exp_cnt);
      applyStimulus(10'd0, 10'd0);
      checkOutput($sformatf("%s_fs", tag), frameStart, 1);
      checkOutput($sformatf("%s_gt_at_fs", tag), genTick, 0);
      applyStimulus(10'd5, 10'd100);
      applyStimulus(10'd639, 10'd479);
      applyStimulus(10'd0, 10'd480);
      checkOutput($sformatf("%s_vb", tag), vblankStart, 1);
      checkOutput($sformatf("%s_gt", tag), genTick, exp_tick);
      checkOutput($sformatf("%s_gt1", tag), gen_tick1, exp_tick1);
      applyStimulus(10'd1, 10'd480);
      checkOutput($sformatf("%s_gt_width", tag), genTick, 0);
      checkOutput($sformatf("%s_gt1_width", tag), gen_tick1, 0);
      checkOutput($sformatf("%s_cnt", tag), dut.u_ctrl.frame_cnt, exp_cnt);
      applyStimulus(10'd400, 10'd520);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int h_list[4];
      int fs_cnt;
      int vb_cnt;
      int vs_low;
      int gt_cnt;

      vecs[0]  = '{10'd0,    10'd0,   1'b1, 1'b1, 1'b1, 10'd0,   9'd0,   1'b1, 1'b0};
      vecs[1]  = '{10'd639,  10'd479, 1'b1, 1'b1, 1'b1, 10'd639, 9'd479, 1'b0, 1'b0};
      vecs[2]  = '{10'd640,  10'd479, 1'b0, 1'b1, 1'b1, 10'd0,   9'd0,   1'b0, 1'b0};
      vecs[3]  = '{10'd639,  10'd480, 1'b0, 1'b1, 1'b1, 10'd0,   9'd0,   1'b0, 1'b0};
      vecs[4]  = '{10'd0,    10'd480, 1'b0, 1'b1, 1'b1, 10'd0,   9'd0,   1'b0, 1'b1};
      vecs[5]  = '{10'd655,  10'd10,  1'b0, 1'b1, 1'b1, 10'd0,   9'd0,   1'b0, 1'b0};
      vecs[6]  = '{10'd656,  10'd10,  1'b0, 1'b0, 1'b1, 10'd0,   9'd0,   1'b0, 1'b0};
      vecs[7]  = '{10'd751,  10'd10,  1'b0, 1'b0, 1'b1, 10'd0,   9'd0,   1'b0, 1'b0};
      vecs[8]  = '{10'd752,  10'd10,  1'b0, 1'b1, 1'b1, 10'd0,   9'd0,   1'b0, 1'b0};
      vecs[9]  = '{10'd100,  10'd489, 1'b0, 1'b1, 1'b1, 10'd0,   9'd0,   1'b0, 1'b0};
      vecs[10] = '{10'd100,  10'd490, 1'b0, 1'b1, 1'b0, 10'd0,   9'd0,   1'b0, 1'b0};
      vecs[11] = '{10'd700,  10'd491, 1'b0, 1'b0, 1'b0, 10'd0,   9'd0,   1'b0, 1'b0};
      vecs[12] = '{10'd0,    10'd492, 1'b0, 1'b1, 1'b1, 10'd0,   9'd0,   1'b0, 1'b0};
      vecs[13] = '{10'd799,  10'd524, 1'b0, 1'b1, 1'b1, 10'd0,   9'd0,   1'b0, 1'b0};
      vecs[14] = '{10'd800,  10'd0,   1'b0, 1'b1, 1'b1, 10'd0,   9'd0,   1'b0, 1'b0};
      vecs[15] = '{10'd0,    10'd525, 1'b0, 1'b1, 1'b1, 10'd0,   9'd0,   1'b0, 1'b0};
      vecs[16] = '{10'd700,  10'd600, 1'b0, 1'b1, 1'b1, 10'd0,   9'd0,   1'b0, 1'b0};
      vecs[17] = '{10'd1023, 10'd490, 1'b0, 1'b1, 1'b1, 10'd0,   9'd0,   1'b0, 1'b0};
      vecs[18] = '{10'd320,  10'd240, 1'b1, 1'b1, 1'b1, 10'd320, 9'd240, 1'b0, 1'b0};

      rst    = 1'b1;
      run    = 1'b0;
      step   = 1'b0;
      hCount = 10'd700;
      vCount = 10'd490;
      repeat (3) @(posedge pixelClk);
      #1;
      checkOutput("rst_hsync", hSync, 1);
      checkOutput("rst_vsync", vSync, 1);
      checkOutput("rst_video", videoOn, 0);
      checkOutput("rst_px", pixelX, 0);
      checkOutput("rst_py", pixelY, 0);
      checkOutput("rst_fs", frameStart, 0);
      checkOutput("rst_vb", vblankStart, 0);
      checkOutput("rst_gt", genTick, 0);
      checkOutput("rst_cnt", dut.u_ctrl.frame_cnt, 0);

      rst    = 1'b0;
      hCount = 10'd0;
      vCount = 10'd0;
      #1;
      checkOutput("lat_fs_before_edge", frameStart, 0);
      @(posedge pixelClk);
      #1;
      checkOutput("lat_fs", frameStart, 1);
      checkOutput("lat_video", videoOn, 1);
      applyStimulus(10'd1, 10'd0);
      checkOutput("lat_fs_drop", frameStart, 0);

      for (int i = 0; i < 19; i++) begin
         applyStimulus(vecs[i].h, vecs[i].v);
         checkOutput($sformatf("vec%0d_video", i), videoOn, vecs[i].vid);
         checkOutput($sformatf("vec%0d_hsync", i), hSync, vecs[i].hs);
         checkOutput($sformatf("vec%0d_vsync", i), vSync, vecs[i].vs);
         checkOutput($sformatf("vec%0d_px", i), pixelX, vecs[i].x);
         checkOutput($sformatf("vec%0d_py", i), pixelY, vecs[i].y);
         checkOutput($sformatf("vec%0d_fs", i), frameStart, vecs[i].fs);
         checkOutput($sformatf("vec%0d_vb", i), vblankStart, vecs[i].vb);
      end

      for (int h = 0; h < 800; h++) begin
         applyStimulus(10'(h), 10'd10);
         checkOutput($sformatf("hsweep%0d_video", h), videoOn, model_video(h, 10));
         checkOutput($sformatf("hsweep%0d_hsync", h), hSync, model_hs(h, 10));
         checkOutput($sformatf("hsweep%0d_px", h), pixelX, model_video(h, 10) ? h : 0);
      end

      h_list = '{0, 1, 700, 799};
      fs_cnt = 0;
      vb_cnt = 0;
      vs_low = 0;
      gt_cnt = 0;
      for (int fr = 0; fr < 2; fr++) begin
         for (int v = 0; v < 525; v++) begin
            for (int k = 0; k < 4; k++) begin
               applyStimulus(10'(h_list[k]), 10'(v));
               if (vSync !== model_vs(h_list[k], v))
                  checkOutput($sformatf("vsweep_v%0d_h%0d", v, h_list[k]), vSync,
                              model_vs(h_list[k], v));
               if (frameStart) fs_cnt++;
               if (vblankStart) vb_cnt++;
               if (!vSync) vs_low++;
               if (genTick) gt_cnt++;
            end
         end
      end
      checkOutput("vsweep_fs_count", fs_cnt, 2);
      checkOutput("vsweep_vb_count", vb_cnt, 2);
      checkOutput("vsweep_vs_low_count", vs_low, 16);
      checkOutput("vsweep_paused_ticks", gt_cnt, 0);

      run = 1'b1;
      for (int i = 1; i <= 9; i++)
         runFrame($sformatf("free%0d", i), (i % 3) == 0, 1'b1, i % 3);
      runFrame("free10", 1'b0, 1'b1, 1);

      run  = 1'b0;
      step = 1'b1;
      applyStimulus(10'd0, 10'd100);
      step = 1'b0;
      applyStimulus(10'd1, 10'd100);
      step = 1'b1;
      applyStimulus(10'd2, 10'd100);
      step = 1'b0;
      runFrame("step_tick", 1'b1, 1'b1, 1);
      runFrame("step_after", 1'b0, 1'b0, 1);

      run  = 1'b1;
      step = 1'b1;
      applyStimulus(10'd0, 10'd100);
      step = 1'b0;
      runFrame("resume1", 1'b0, 1'b1, 2);
      runFrame("resume2", 1'b1, 1'b1, 0);
      runFrame("resume3", 1'b0, 1'b1, 1);

      run  = 1'b0;
      step = 1'b1;
      applyStimulus(10'd0, 10'd100);
      step = 1'b0;
      run  = 1'b1;
      applyStimulus(10'd1, 10'd100);
      run  = 1'b0;
      runFrame("run_clears_step", 1'b0, 1'b0, 1);

      step = 1'b1;
      applyStimulus(10'd0, 10'd200);
      step = 1'b0;
      rst  = 1'b1;
      applyStimulus(10'd0, 10'd300);
      rst  = 1'b0;
      checkOutput("midrst_cnt", dut.u_ctrl.frame_cnt, 0);
      checkOutput("midrst_video", videoOn, 0);
      checkOutput("midrst_gt", genTick, 0);
      runFrame("midrst_frame", 1'b0, 1'b0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter FRAMES_PER_GEN, default 30, frames between automatic generation ticks (legal 1..255).
REQ-002 pixelClk  input  1  25 MHz pixel clock; the only clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 hCount  input  10  horizontal count, 0..799.
REQ-005 vCount  input  10  vertical count, 0..524.
REQ-006 run  input  1  1 = free-running generation ticks; 0 = paused.
REQ-007 step  input  1  single-cycle request for one generation tick while paused.
REQ-008 hSync  output  1  horizontal sync, active-low.
REQ-009 vSync  output  1  vertical sync, active-low.
REQ-010 videoOn  output  1  high in the visible 640x480 region.
REQ-011 pixelX  output  10  visible column; 0 when videoOn=0.
REQ-012 pixelY  output  9  visible row; 0 when videoOn=0.
REQ-013 frameStart  output  1  one-cycle pulse at count (0,0).
REQ-014 vblankStart  output  1  one-cycle pulse at count (0,480).
REQ-015 genTick  output  1  one-cycle pulse that advances the Game-of-Life engine.

Function
REQ-016 All outputs are registered. Each output reflects the hCount/vCount presented one pixelClk earlier, for a fixed latency of 1 cycle.
REQ-017 Visible region: videoOn=1 iff hCount<=639 and vCount<=479. In that region pixelX=hCount and pixelY=vCount[8:0].
REQ-018 hSync=0 iff 656<=hCount<=751.
REQ-019 vSync=0 iff 490<=vCount<=491. vSync is independent of hCount.
REQ-020 Out-of-range counts (hCount>=800 or vCount>=525) give videoOn=0 and both syncs high. No pulses are produced for them.
REQ-021 frameStart=1 iff hCount==0 and vCount==0. vblankStart=1 iff hCount==0 and vCount==480.
REQ-022 Frame counter: 8 bits, range 0..FRAMES_PER_GEN-1.
  - run=1: increments on each vblankStart event.
  - run=0: holds its value.
REQ-023 With run=1, genTick fires coincident with vblankStart when frameCnt==FRAMES_PER_GEN-1. frameCnt then wraps to 0.
REQ-024 Step latch: sets on step=1 while run=0. While set, the next vblankStart event fires genTick and clears the latch. frameCnt is unchanged by a step tick.
REQ-025 step while run=1 is ignored. Multiple steps before the same vblankStart yield a single genTick.
REQ-026 Clearing run mid-count: frameCnt holds, and resumes from the held value when run returns to 1.
  - Setting run clears any pending step latch.
REQ-027 genTick never fires outside a vblankStart cycle, and never fires more than once per frame.
REQ-028 FRAMES_PER_GEN=1: genTick on every vblankStart while run=1.

Reset
REQ-029 While rst=1 at a pixelClk edge, outputs take these values:
  - hSync=1, vSync=1.
  - videoOn=0, pixelX=0, pixelY=0.
  - frameStart=0, vblankStart=0, genTick=0.
  - frameCnt=0, step latch=0.
REQ-030 Reset asserted mid-frame or mid-count aborts any pending tick. The first valid output follows 1 cycle after rst falls.

Structure
REQ-031 A shared package vga_pkg holds the timing constants:
  - H_VISIBLE=640, H_FP=16, H_SYNC=96, H_BP=48, H_TOTAL=800.
  - V_VISIBLE=480, V_FP=10, V_SYNC=2, V_BP=33, V_TOTAL=525.
  - Widths are derived from these via $clog2.
REQ-032 One sub-module, gen_tick_ctrl, holds the frame counter, the step latch and the genTick logic. The decode and output registers sit in vga_sync_gen.

Verification
REQ-033 Reset and pipeline latency:
  - Hold rst 3 cycles -> outputs match REQ-029.
  - Drive (hCount=0, vCount=0) -> frameStart=1 and videoOn=1 exactly 1 cycle later.
REQ-034 Horizontal sweep: hCount 0..799 with vCount=10 ->
  - videoOn high for hCount 0..639.
  - hSync low for hCount 656..751 only.
  - pixelX tracks hCount.
REQ-035 Vertical sweep: full frames driven by an H/V counter model ->
  - vSync low only on lines 490-491.
  - exactly one frameStart and one vblankStart per 420000 cycles.
REQ-036 Free run, run=1, FRAMES_PER_GEN=3, 9 frames ->
  - genTick on the vblankStart of frames 3, 6 and 9 only.
  - each genTick is 1 cycle wide.
REQ-037 Pause and step: run=0, pulse step twice at line 100 ->
  - exactly one genTick at the next vblankStart.
  - frameCnt unchanged.
  - step with run=1 produces no extra tick.
REQ-038 Mid-operation reset: rst asserted for 1 cycle at line 300 with a step pending ->
  - no genTick at the following vblankStart.
  - frameCnt=0.
